// File: rtl/alu_pkg.sv
// Shared ALU package: divide-sequencer state encoding, default datapath width
// and the quotient returned for a divide by zero.
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    localparam logic [ALU_WIDTH-1:0] DIV_ZERO_QUOT = {ALU_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_ITER = 2'd1,
        DIV_FIN  = 2'd2
    } div_state_e;

endpackage

// File: rtl/alu_sub_unit.sv
// Combinational WIDTH+1-bit subtractor computing a + ~b + 1.
// carry_out = 1 means no borrow, i.e. a >= b.
module alu_sub_unit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    output logic [WIDTH:0] diff,
    output logic           carry_out
);

    logic [WIDTH+1:0] sum_s;

    // Two's-complement subtract with the carry kept as the no-borrow flag
    always_comb begin
        sum_s     = {1'b0, a} + {1'b0, ~b} + {{(WIDTH+1){1'b0}}, 1'b1};
        diff      = sum_s[WIDTH:0];
        carry_out = sum_s[WIDTH+1];
    end

endmodule

// File: rtl/alu_div_seq.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Optional abort input enabled by defining ALU_DIV_ABORT_EN.
module alu_div_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef ALU_DIV_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_e       state_r;
    logic [WIDTH-1:0] p_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] d_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] quot_r;
    logic [WIDTH-1:0] rem_r;
    logic             dbz_r;

    logic [WIDTH:0]   s_s;
    logic [WIDTH:0]   diff_s;
    logic             carry_s;
    logic [WIDTH-1:0] p_next_s;
    logic [WIDTH-1:0] q_next_s;
    logic             abort_s;
    logic             unused_s;

`ifdef ALU_DIV_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    alu_sub_unit #(.WIDTH(WIDTH)) u_sub (
        .a         (s_s),
        .b         ({1'b0, d_r}),
        .diff      (diff_s),
        .carry_out (carry_s)
    );

    // One restoring step: shift in the next dividend bit, keep the difference if no borrow.
    // The partial remainder stays below the divisor, so the top bits of S and the difference are always zero.
    always_comb begin
        s_s      = {p_r, q_r[WIDTH-1]};
        p_next_s = carry_s ? diff_s[WIDTH-1:0] : s_s[WIDTH-1:0];
        q_next_s = {q_r[WIDTH-2:0], carry_s};
        unused_s = ^{diff_s[WIDTH], s_s[WIDTH]};
    end

    // Sequencer state, datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= DIV_IDLE;
            p_r     <= {WIDTH{1'b0}};
            q_r     <= {WIDTH{1'b0}};
            d_r     <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            quot_r  <= {WIDTH{1'b0}};
            rem_r   <= {WIDTH{1'b0}};
            dbz_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                DIV_IDLE: begin
                    if (start) begin
                        busy_r <= 1'b1;
                        dbz_r  <= 1'b0;
                        if (divisor != {WIDTH{1'b0}}) begin
                            q_r     <= dividend;
                            d_r     <= divisor;
                            p_r     <= {WIDTH{1'b0}};
                            cnt_r   <= CNT_W'(WIDTH);
                            state_r <= DIV_ITER;
                        end else begin
                            quot_r  <= {WIDTH{DIV_ZERO_QUOT[0]}};
                            rem_r   <= dividend;
                            dbz_r   <= 1'b1;
                            state_r <= DIV_FIN;
                        end
                    end
                end
                DIV_ITER: begin
                    if (abort_s) begin
                        busy_r  <= 1'b0;
                        state_r <= DIV_IDLE;
                    end else begin
                        p_r   <= p_next_s;
                        q_r   <= q_next_s;
                        cnt_r <= cnt_r - CNT_W'(1);
                        if (cnt_r == CNT_W'(1)) begin
                            quot_r  <= q_next_s;
                            rem_r   <= p_next_s;
                            state_r <= DIV_FIN;
                        end
                    end
                end
                DIV_FIN: begin
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= DIV_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= DIV_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quot_r;
    assign remainder   = rem_r;
    assign div_by_zero = dbz_r;

endmodule
